systolic_fir_tap: RTL and testbench

//  One tap of the inferred systolic FIR. Consumes the sample stream through an internal
//  two-stage delay, multiplies the delayed sample by a double-buffered coefficient and adds
//  the upstream partial sum. Taps chain directly: x_out feeds the next tap's x_in, and pout

---
 rtl/systolic_fir_tap_pkg.sv | 45 ++++
 rtl/systolic_fir_tap_if.sv | 30 +++
 rtl/systolic_fir_tap_acc.sv | 59 +++++
 rtl/systolic_fir_tap.sv | 78 +++++++
 tb/tb_systolic_fir_tap.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/systolic_fir_tap_pkg.sv
// Shared widths, types and the saturating-add helper for the systolic FIR tap.
// Optional feature macro: SYSTOLIC_TAP_SAT_EN (saturating accumulate with sticky ovf).
package systolic_fir_pkg;

  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int ACC_W  = 48;
  localparam int SAT_W  = 64;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic {COEF_EMPTY, COEF_LOADED} coef_state_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] sum;
    logic                    ovf;
  } sat_res_t;

  // Operands must already be sign-extended from at most w bits, with w < SAT_W,
  // so the SAT_W-bit sum itself can never wrap.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             w);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t r;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_fir_tap_if.sv
// Data, partial-sum and coefficient-chain signals of one systolic FIR tap.
interface systolic_fir_tap_if
  import systolic_fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int COEF_WIDTH = COEF_W,
  parameter int ACC_WIDTH  = ACC_W
);
  logic                         ena;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic signed [ACC_WIDTH-1:0]  pin;
  logic signed [ACC_WIDTH-1:0]  pout;
  logic signed [COEF_WIDTH-1:0] coef_sin;
  logic                         coef_shift;
  logic signed [COEF_WIDTH-1:0] coef_sout;
  logic                         coef_commit;
  logic                         coef_valid;
  logic                         ovf;

  modport master (
    output ena, x_in, pin, coef_sin, coef_shift, coef_commit,
    input  x_out, pout, coef_sout, coef_valid, ovf
  );

  modport slave (
    input  ena, x_in, pin, coef_sin, coef_shift, coef_commit,
    output x_out, pout, coef_sout, coef_valid, ovf
  );
endinterface

// File: rtl/systolic_fir_tap_acc.sv
// Registered partial-sum stage: pout <= pin + sext(m) on enabled edges.
// Wraps by default; with SYSTOLIC_TAP_SAT_EN it clamps and raises a sticky ovf.
module fir_tap_acc
  import systolic_fir_pkg::*;
#(
  parameter int PROD_WIDTH = 36,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                         clk,
  input  logic                         aclr,
  input  logic                         ena_i,
`ifdef SYSTOLIC_TAP_SAT_EN
  input  logic                         ovf_clr_i,
`endif
  input  logic signed [ACC_WIDTH-1:0]  pin_i,
  input  logic signed [PROD_WIDTH-1:0] m_i,
  output logic signed [ACC_WIDTH-1:0]  pout_o,
  output logic                         ovf_o
);
  logic signed [ACC_WIDTH-1:0] pout_q, pout_d;

`ifdef SYSTOLIC_TAP_SAT_EN
  sat_res_t res;
  logic     ovf_q;

  always_comb begin
    res    = sat_add({{(SAT_W-ACC_WIDTH){pin_i[ACC_WIDTH-1]}}, pin_i},
                     {{(SAT_W-PROD_WIDTH){m_i[PROD_WIDTH-1]}}, m_i},
                     ACC_WIDTH);
    pout_d = res.sum[ACC_WIDTH-1:0];
  end

  // A clamp on the same edge as a commit wins, so the fresh event is not lost.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ovf_q <= 1'b0;
    end else if (ena_i && res.ovf) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign pout_d = pin_i + {{(ACC_WIDTH-PROD_WIDTH){m_i[PROD_WIDTH-1]}}, m_i};
  assign ovf_o  = 1'b0;
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      pout_q <= '0;
    end else if (ena_i) begin
      pout_q <= pout_d;
    end
  end

  assign pout_o = pout_q;
endmodule

// File: rtl/systolic_fir_tap.sv
// One systolic FIR tap: 2-deep sample delay, registered multiply, registered add of pin.
// Double-buffered coefficient loaded via a serial daisy chain; optional SYSTOLIC_TAP_SAT_EN.
module systolic_fir_tap
  import systolic_fir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int COEF_WIDTH = COEF_W,
  parameter int ACC_WIDTH  = ACC_W
) (
  input logic               clk,
  input logic               aclr,
  systolic_fir_tap_if.slave bus
);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  if (ACC_WIDTH < PROD_WIDTH + 1) begin : g_width_chk
    $error("systolic_fir_tap: ACC_WIDTH must be >= DATA_WIDTH+COEF_WIDTH+1");
  end
  if (ACC_WIDTH >= SAT_W) begin : g_sat_width_chk
    $error("systolic_fir_tap: ACC_WIDTH must be < SAT_W");
  end

  logic signed [DATA_WIDTH-1:0] x_d1_q, x_d2_q;
  logic signed [PROD_WIDTH-1:0] m_q, m_d;
  logic signed [COEF_WIDTH-1:0] coef_sh_q, coef_act_q;
  coef_state_e                  coef_state_q;

  assign m_d = x_d2_q * coef_act_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      x_d1_q <= '0;
      x_d2_q <= '0;
      m_q    <= '0;
    end else if (bus.ena) begin
      x_d1_q <= bus.x_in;
      x_d2_q <= x_d1_q;
      m_q    <= m_d;
    end
  end

  // Independent of ena; commit samples the shadow before any same-cycle shift.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      coef_sh_q    <= '0;
      coef_act_q   <= '0;
      coef_state_q <= COEF_EMPTY;
    end else begin
      if (bus.coef_shift) begin
        coef_sh_q <= bus.coef_sin;
      end
      if (bus.coef_commit) begin
        coef_act_q   <= coef_sh_q;
        coef_state_q <= COEF_LOADED;
      end
    end
  end

  fir_tap_acc #(
    .PROD_WIDTH(PROD_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .clk      (clk),
    .aclr     (aclr),
    .ena_i    (bus.ena),
`ifdef SYSTOLIC_TAP_SAT_EN
    .ovf_clr_i(bus.coef_commit),
`endif
    .pin_i    (bus.pin),
    .m_i      (m_q),
    .pout_o   (bus.pout),
    .ovf_o    (bus.ovf)
  );

  assign bus.x_out      = x_d2_q;
  assign bus.coef_sout  = coef_sh_q;
  assign bus.coef_valid = (coef_state_q == COEF_LOADED);
endmodule

// File: tb/tb_systolic_fir_tap.sv
// Directed bench for systolic_fir_tap; honours SYSTOLIC_TAP_SAT_EN for the overflow case.
module tb_systolic_fir_tap;
  import systolic_fir_pkg::*;

  logic clk = 1'b0;
  logic aclr;
  int   checks = 0;
  int   errors = 0;

  systolic_fir_tap_if bus ();

  systolic_fir_tap dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_coef(input coef_t c);
    bus.coef_sin   = c;
    bus.coef_shift = 1'b1;
    tick();
    bus.coef_shift  = 1'b0;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
  endtask

  logic signed [63:0] max47;

  initial begin
    max47           = (64'sd1 <<< 47) - 64'sd1;
    aclr            = 1'b1;
    bus.ena         = 1'b0;
    bus.x_in        = '0;
    bus.pin         = '0;
    bus.coef_sin    = '0;
    bus.coef_shift  = 1'b0;
    bus.coef_commit = 1'b0;
    tick();
    chk("rst_pout", bus.pout, 0);
    chk("rst_xout", bus.x_out, 0);
    chk("rst_sout", bus.coef_sout, 0);
    chk("rst_valid", bus.coef_valid, 0);
    chk("rst_ovf", bus.ovf, 0);
    aclr    = 1'b0;
    bus.ena = 1'b1;

    // 1: impulse through coef=3
    load_coef(18'sd3);
    chk("t1_valid", bus.coef_valid, 1);
    bus.x_in = 18'sd1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      bus.x_in = '0;
      chk($sformatf("t1_xout_%0d", i), bus.x_out, (i == 2) ? 1 : 0);
      chk($sformatf("t1_pout_%0d", i), bus.pout, (i == 4) ? 3 : 0);
    end

    // 2: daisy chain, then simultaneous shift+commit
    bus.coef_shift = 1'b1;
    bus.coef_sin   = 18'sd5;
    tick();
    bus.coef_sin = 18'sd7;
    tick();
    bus.coef_shift = 1'b0;
    chk("t2_sout7", bus.coef_sout, 7);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    bus.x_in = 18'sd1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.x_in = '0;
      if (i >= 3) chk($sformatf("t2_pout_%0d", i), bus.pout, (i == 4) ? 7 : 0);
    end
    bus.coef_sin    = 18'sd9;
    bus.coef_shift  = 1'b1;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_shift  = 1'b0;
    bus.coef_commit = 1'b0;
    chk("t2_sout9", bus.coef_sout, 9);
    bus.x_in = 18'sd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.x_in = '0;
    end
    chk("t2_pout_act7", bus.pout, 7);
    tick();

    // 3: stall mid-impulse; coefficient chain still shifts
    load_coef(18'sd3);
    bus.x_in = 18'sd1;
    tick();
    bus.x_in = '0;
    tick();
    bus.ena        = 1'b0;
    bus.x_in       = 18'sd5;
    bus.coef_sin   = 18'sd11;
    bus.coef_shift = 1'b1;
    tick();
    bus.coef_shift = 1'b0;
    chk("t3_stall_sout", bus.coef_sout, 11);
    tick();
    tick();
    chk("t3_hold_xout", bus.x_out, 1);
    chk("t3_hold_pout", bus.pout, 0);
    bus.ena  = 1'b1;
    bus.x_in = '0;
    tick();
    chk("t3_pout_k6", bus.pout, 0);
    tick();
    chk("t3_pout_k7", bus.pout, 3);
    tick();
    chk("t3_pout_k8", bus.pout, 0);

    // 4: passthrough while EMPTY, then coef=-2
    #3 aclr = 1'b1;
    #1 aclr = 1'b0;
    chk("t4_valid0", bus.coef_valid, 0);
    bus.pin = 48'sd1000;
    tick();
    chk("t4_pass", bus.pout, 1000);
    load_coef(-18'sd2);
    bus.x_in = 18'sd4;
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.x_in = '0;
      if (i >= 3) chk($sformatf("t4_pout_%0d", i), bus.pout, (i == 4) ? 992 : 1000);
    end

    // 5: accumulator overflow
    load_coef(18'sd1);
    bus.pin  = 48'sh7FFF_FFFF_FFFF;
    bus.x_in = 18'sd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.x_in = '0;
    end
`ifdef SYSTOLIC_TAP_SAT_EN
    chk("t5_pout_sat", bus.pout, max47);
    chk("t5_ovf_set", bus.ovf, 1);
    tick();
    chk("t5_ovf_sticky", bus.ovf, 1);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("t5_ovf_clr", bus.ovf, 0);
`else
    chk("t5_pout_wrap", bus.pout, -max47 - 64'sd1);
    chk("t5_ovf_zero", bus.ovf, 0);
`endif

    // 6: asynchronous reset mid-stream
    bus.pin  = 48'sd5;
    bus.x_in = 18'sd10;
    tick();
    tick();
    tick();
    #3 aclr = 1'b1;
    #1;
    chk("t6_pout", bus.pout, 0);
    chk("t6_xout", bus.x_out, 0);
    chk("t6_sout", bus.coef_sout, 0);
    chk("t6_valid", bus.coef_valid, 0);
    chk("t6_ovf", bus.ovf, 0);
    aclr     = 1'b0;
    bus.x_in = '0;
    tick();
    chk("t6_resume", bus.pout, 5);
    chk("t6_valid_after", bus.coef_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
